// File: rtl/data_memory_unit.sv
// MEM-stage data memory: byte-addressed, word-organised RAM with sized/extended loads,
// byte-enabled stores, fault detection and a valid/ready port with configurable read latency.
module data_memory_unit #(
    parameter int unsigned DEPTH_WORDS  = 512,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_fault,
    output logic [31:0] o_fault_addr
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      r_state;
    logic [2:0]  r_cnt;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_fault;
    logic [31:0] r_fault_addr;
    logic [31:0] r_pend_rdata;
    logic        r_pend_fault;
    logic [31:0] r_pend_addr;

    // Contents survive reset; only power-up clears them.
    logic [31:0] r_mem [DEPTH_WORDS] = '{default: '0};

    logic          w_accept;
    logic [AW-1:0] w_idx;
    logic          w_range_err;
    logic          w_align_err;
    logic          w_fault;
    logic [3:0]    w_be;
    logic [31:0]   w_wlanes;
    logic [31:0]   w_rword;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_ldata;

    assign o_req_ready  = (r_state != StWait);
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_rdata  = r_rsp_rdata;
    assign o_rsp_fault  = r_rsp_fault;
    assign o_fault_addr = r_fault_addr;

    assign w_accept    = i_req_valid & o_req_ready & ~i_reset;
    assign w_idx       = i_req_addr[AW+1:2];
    assign w_range_err = |i_req_addr[31:AW+2];
    assign w_fault     = w_range_err | w_align_err;

    always_comb begin
        w_align_err = 1'b0;
        w_be        = 4'b0000;
        w_wlanes    = i_req_wdata;
        case (i_req_size)
            2'b00: begin
                w_be     = 4'b0001 << i_req_addr[1:0];
                w_wlanes = {4{i_req_wdata[7:0]}};
            end
            2'b01: begin
                w_align_err = i_req_addr[0];
                w_be        = i_req_addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes    = {2{i_req_wdata[15:0]}};
            end
            2'b10: begin
                w_align_err = (i_req_addr[1:0] != 2'b00);
                w_be        = 4'b1111;
            end
            default: w_align_err = 1'b1;
        endcase
    end

    assign w_rword = r_mem[w_idx];
    assign w_byte  = w_rword[{i_req_addr[1:0], 3'b000} +: 8];
    assign w_half  = w_rword[{i_req_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_ldata = '0;
        if (!i_req_write && !w_fault) begin
            case (i_req_size)
                2'b00:   w_ldata = {{24{~i_req_unsigned & w_byte[7]}}, w_byte};
                2'b01:   w_ldata = {{16{~i_req_unsigned & w_half[15]}}, w_half};
                default: w_ldata = w_rword;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept && i_req_write && !w_fault) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_fault  <= 1'b0;
            r_fault_addr <= '0;
            r_pend_rdata <= '0;
            r_pend_fault <= 1'b0;
            r_pend_addr  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                StIdle, StResp: begin
                    if (!w_accept) begin
                        r_state <= StIdle;
                    end else if (READ_LATENCY == 1) begin
                        r_state     <= StResp;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_ldata;
                        r_rsp_fault <= w_fault;
                        if (w_fault) r_fault_addr <= i_req_addr;
                    end else begin
                        r_state      <= StWait;
                        r_cnt        <= 3'(READ_LATENCY - 1);
                        r_pend_rdata <= w_ldata;
                        r_pend_fault <= w_fault;
                        r_pend_addr  <= i_req_addr;
                    end
                end
                StWait: begin
                    if (r_cnt == 3'd1) begin
                        r_state     <= StResp;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_pend_rdata;
                        r_rsp_fault <= r_pend_fault;
                        if (r_pend_fault) r_fault_addr <= r_pend_addr;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_unit.sv
// Scoreboard bench: two instances (latency 1 and 3) checked against a byte-array memory model.
module tb_data_memory_unit;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned BYTES = 4 * DEPTH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [2];
    logic        req_valid [2];
    logic        req_write [2];
    logic [1:0]  req_size  [2];
    logic        req_uns   [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rdy       [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_fault [2];
    logic [31:0] fault_addr[2];

    data_memory_unit #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(1)) u_dut0 (
        .i_clk(clk), .i_reset(rst[0]), .i_req_valid(req_valid[0]), .o_req_ready(rdy[0]),
        .i_req_write(req_write[0]), .i_req_size(req_size[0]), .i_req_unsigned(req_uns[0]),
        .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]), .o_rsp_valid(rsp_valid[0]),
        .o_rsp_rdata(rsp_rdata[0]), .o_rsp_fault(rsp_fault[0]), .o_fault_addr(fault_addr[0])
    );

    data_memory_unit #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(3)) u_dut1 (
        .i_clk(clk), .i_reset(rst[1]), .i_req_valid(req_valid[1]), .o_req_ready(rdy[1]),
        .i_req_write(req_write[1]), .i_req_size(req_size[1]), .i_req_unsigned(req_uns[1]),
        .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]), .o_rsp_valid(rsp_valid[1]),
        .o_rsp_rdata(rsp_rdata[1]), .o_rsp_fault(rsp_fault[1]), .o_fault_addr(fault_addr[1])
    );

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        logic [31:0] faddr;
        int          cyc;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [7:0]  mmem [2][BYTES];
    logic [31:0] m_faddr [2];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%08h, want 0x%08h", name, d, act, exp);
        end
    endtask

    // Reference: memory as a flat byte array, little-endian assembly of the accessed bytes.
    function automatic exp_t model(input int d, input bit wr, input logic [1:0] sz, input bit un,
                                   input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        int          n;
        logic [31:0] v;
        bit          f;
        f = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
            (a >= BYTES);
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        v = '0;
        if (!f) begin
            for (int i = 0; i < n; i++) begin
                if (wr) mmem[d][int'(a) + i] = wd[8*i +: 8];
                else    v[8*i +: 8] = mmem[d][int'(a) + i];
            end
        end
        if (!un && n == 1 && v[7])  v[31:8]  = '1;
        if (!un && n == 2 && v[15]) v[31:16] = '1;
        if (wr || f) v = '0;
        if (f) m_faddr[d] = a;
        e.rdata = v;
        e.fault = f;
        e.faddr = m_faddr[d];
        e.cyc   = 0;
        return e;
    endfunction

    task automatic issue(input int d, input bit wr, input logic [1:0] sz, input bit un,
                         input logic [31:0] a, input logic [31:0] wd, output int waits);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_size[d]  = sz;
        req_uns[d]   = un;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        while (!rdy[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        waits = n;
        if (!rdy[d]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout dut%0d: req_ready=0 after %0d cycles, want 1", d, n);
            req_valid[d] = 1'b0;
            return;
        end
        if (d == 0) check("ready_never_drops", d, n, 0);
        @(posedge clk);
        #1;
        e     = model(d, wr, sz, un, a, wd);
        e.cyc = cyc + lat(d) - 1;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        req_valid[d] = 1'b0;
    endtask

    task automatic check_idle(input int d);
        check("reset_rsp_valid", d, {31'b0, rsp_valid[d]}, 32'd0);
        check("reset_rsp_rdata", d, rsp_rdata[d], 32'd0);
        check("reset_rsp_fault", d, {31'b0, rsp_fault[d]}, 32'd0);
        check("reset_fault_addr", d, fault_addr[d], 32'd0);
        check("reset_req_ready", d, {31'b0, rdy[d]}, 32'd1);
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", d, (d == 0) ? q0.size() : q1.size(), 0);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rsp_valid[d]) begin
                exp_t e;
                if (((d == 0) ? q0.size() : q1.size()) == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp dut%0d: rsp_valid=1, want 0", d);
                end else begin
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    check("rsp_rdata", d, rsp_rdata[d], e.rdata);
                    check("rsp_fault", d, {31'b0, rsp_fault[d]}, {31'b0, e.fault});
                    check("fault_addr", d, fault_addr[d], e.faddr);
                    check("rsp_cycle", d, cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1);
    end

    initial begin
        int          w;
        logic [1:0]  sz;
        logic [31:0] a;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0; req_size[d] = 2'd0;
            req_uns[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0; m_faddr[d] = '0;
            for (int i = 0; i < BYTES; i++) mmem[d][i] = 8'h00;
        end
        repeat (2) @(negedge clk);
        check_idle(0);
        check_idle(1);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Store then back-to-back word load.
        issue(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, w);
        issue(0, 0, 2'd2, 0, 32'h10, 32'h0, w);
        // Sub-word loads with sign/zero extension.
        issue(0, 0, 2'd0, 0, 32'h13, 32'h0, w);
        issue(0, 0, 2'd0, 1, 32'h13, 32'h0, w);
        issue(0, 0, 2'd1, 0, 32'h10, 32'h0, w);
        issue(0, 0, 2'd1, 1, 32'h12, 32'h0, w);
        // Byte store merges into one lane.
        issue(0, 1, 2'd0, 0, 32'h11, 32'h55, w);
        issue(0, 0, 2'd2, 0, 32'h10, 32'h0, w);
        // Faults: misaligned half, misaligned word store, out of range, illegal size.
        issue(0, 0, 2'd1, 0, 32'h11, 32'h0, w);
        issue(0, 1, 2'd2, 0, 32'h12, 32'hFFFFFFFF, w);
        issue(0, 0, 2'd2, 0, 32'h800, 32'h0, w);
        issue(0, 0, 2'd3, 0, 32'h10, 32'h0, w);
        issue(0, 0, 2'd2, 0, 32'h10, 32'h0, w);
        drain(0);

        // Latency 3: a held request is accepted only in the response cycle.
        issue(1, 1, 2'd2, 0, 32'h30, 32'hCAFEF00D, w);
        issue(1, 0, 2'd2, 0, 32'h30, 32'h0, w);
        check("ready_low_cycles", 1, w, 2);
        issue(1, 0, 2'd1, 0, 32'h32, 32'h0, w);
        check("held_accept_wait", 1, w, 2);
        drain(1);

        // Reset during a pending store response: response dropped, store kept.
        issue(1, 1, 2'd2, 0, 32'h20, 32'h12345678, w);
        @(negedge clk);
        rst[1] = 1'b1;
        q1.delete();
        m_faddr[1] = '0;
        @(negedge clk);
        check_idle(1);
        @(negedge clk);
        rst[1] = 1'b0;
        repeat (4) @(negedge clk);
        issue(1, 0, 2'd2, 0, 32'h20, 32'h0, w);
        drain(1);

        for (int k = 0; k < 240; k++) begin
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            case ($urandom_range(0, 19))
                0:       a = BYTES + $urandom_range(0, 63);
                1:       a = 32'h8000_0000 | $urandom_range(0, 63);
                default: a = $urandom_range(0, 63);
            endcase
            if ($urandom_range(0, 7) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            issue(k % 2, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, w);
        end
        drain(0);
        drain(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
